// File: rtl/code_conv_sched.sv
// code_conv_sched: round-robin arbitrated Gray/binary converter with a tagged valid/ready response
module code_conv_sched #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_mode,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_mode,
  output logic                  busy,
  output logic [CNTW-1:0]       op_count
);
  typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;
  state_t state, state_d;
  logic [IDW-1:0] ptr, g, op_id;
  logic [2*NREQ-1:0] vv;
  logic [NREQ-1:0] rot;
  logic any, op_mode;
  logic [WIDTH-1:0] op_x, g2b;
  // rotate valids so bit 0 is the pointer position, then pick the lowest set bit
  always_comb begin
    vv = {req_valid, req_valid} >> ptr;
    rot = vv[NREQ-1:0];
    g = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (rot[k]) begin
        g = IDW'((int'(ptr) + k) % NREQ);
        any = 1'b1;
      end
  end
  // Gray decode: each binary bit is the xor of all Gray bits at or above it
  always_comb begin
    g2b = '0;
    for (int i = 0; i < WIDTH; i++) g2b[i] = ^(op_x >> i);
  end
  // next state and grant
  always_comb begin
    state_d = state;
    req_ready = '0;
    case (state)
      IDLE: if (any) begin
        state_d = CONV;
        req_ready = NREQ'(1) << g;
      end
      CONV: state_d = RESP;
      default: state_d = rsp_ready ? IDLE : state;
    endcase
  end
  assign rsp_valid = (state == RESP);
  assign busy = (state != IDLE);
  // state, operand capture, result register and saturating completion counter
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      op_x <= '0;
      op_mode <= 1'b0;
      op_id <= '0;
      rsp_data <= '0;
      rsp_id <= '0;
      rsp_mode <= 1'b0;
      op_count <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && any) begin
        op_x <= req_data[int'(g)*WIDTH +: WIDTH];
        op_mode <= req_mode[g];
        op_id <= g;
        ptr <= IDW'((int'(g) + 1) % NREQ);
      end
      if (state == CONV) begin
        rsp_data <= op_mode ? op_x ^ (op_x >> 1) : g2b;
        rsp_id <= op_id;
        rsp_mode <= op_mode;
      end
      if (state == RESP && rsp_ready && op_count != '1) op_count <= op_count + CNTW'(1);
    end
endmodule
